// File: rtl/boot_seq_ctrl.sv
// Boot sequencer: holds the SoC in reset, waits for an SPI image load,
// then releases fetch and guards the running core with a watchdog.
module boot_seq_ctrl #(
    parameter int unsigned RST_HOLD_CYCLES = 16,
    parameter int unsigned CS_IDLE_CYCLES  = 64,
    parameter int unsigned WDT_CYCLES      = 1048576
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       boot_req_i,
    input  logic       spi_cs_i,
    input  logic       monitor_valid,
    output logic       soc_rst_n_o,
    output logic       fetch_enable_o,
    output logic [1:0] state_o,
    output logic       wdt_expired_o
);

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

    // Terminal values: the transition fires on the edge that would make
    // the counter reach its target.
    localparam logic [7:0]  HOLD_LAST = 8'(RST_HOLD_CYCLES - 1);
    localparam logic [15:0] IDLE_LAST = 16'(CS_IDLE_CYCLES - 1);
    localparam logic [23:0] WDT_LAST  = 24'(WDT_CYCLES - 1);
    localparam logic        WDT_EN    = (WDT_CYCLES != 0);

    state_e      state_q, state_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic [15:0] idle_cnt_q, idle_cnt_d;
    logic [23:0] wdt_cnt_q, wdt_cnt_d;
    logic        cs_seen_q, cs_seen_d;
    logic        cs_meta_q, cs_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_meta_q <= 1'b1;
            cs_sync_q <= 1'b1;
        end else begin
            cs_meta_q <= spi_cs_i;
            cs_sync_q <= cs_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= '0;
            idle_cnt_q <= '0;
            wdt_cnt_q  <= '0;
            cs_seen_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            wdt_cnt_q  <= wdt_cnt_d;
            cs_seen_q  <= cs_seen_d;
        end
    end

    // Counters default to zero so every state entry starts them clean.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = '0;
        idle_cnt_d = '0;
        wdt_cnt_d  = '0;
        cs_seen_d  = 1'b0;
        unique case (state_q)
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_LOAD;
                end else if (hold_cnt_q != 8'hFF) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end else begin
                    hold_cnt_d = hold_cnt_q;
                end
            end
            ST_LOAD: begin
                if (boot_req_i) begin
                    state_d = ST_RUN;
                end else begin
                    cs_seen_d = cs_seen_q | ~cs_sync_q;
                    if (!cs_sync_q) begin
                        idle_cnt_d = '0;
                    end else if (cs_seen_q) begin
                        if (idle_cnt_q == IDLE_LAST) begin
                            state_d = ST_RUN;
                        end else if (idle_cnt_q != 16'hFFFF) begin
                            idle_cnt_d = idle_cnt_q + 16'd1;
                        end else begin
                            idle_cnt_d = idle_cnt_q;
                        end
                    end else begin
                        idle_cnt_d = idle_cnt_q;
                    end
                end
            end
            ST_RUN: begin
                if (boot_req_i) begin
                    state_d = ST_HOLD;
                end else if (monitor_valid) begin
                    wdt_cnt_d = '0;
                end else if (WDT_EN && wdt_cnt_q == WDT_LAST) begin
                    state_d = ST_FAULT;
                end else if (wdt_cnt_q != 24'hFFFFFF) begin
                    wdt_cnt_d = wdt_cnt_q + 24'd1;
                end else begin
                    wdt_cnt_d = wdt_cnt_q;
                end
            end
            ST_FAULT: begin
                if (boot_req_i) begin
                    state_d = ST_HOLD;
                end
            end
        endcase
    end

    always_comb begin
        soc_rst_n_o    = (state_q != ST_HOLD);
        fetch_enable_o = (state_q == ST_RUN);
        wdt_expired_o  = (state_q == ST_FAULT);
        state_o        = state_q;
    end

endmodule

// File: tb/tb_boot_seq_ctrl.sv
// Directed bench for boot_seq_ctrl: expected states are queued by the
// stimulus and checked against all outputs by an independent monitor.
module tb_boot_seq_ctrl;

    localparam logic [1:0] S_HOLD  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       boot_req = 1'b0;
    logic       spi_cs   = 1'b1;
    logic       mv       = 1'b0;
    logic       soc_rst_n;
    logic       fe;
    logic       wdt_exp;
    logic [1:0] st;

    typedef struct {
        string      name;
        logic [1:0] st;
    } exp_t;

    exp_t sb_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    boot_seq_ctrl #(
        .RST_HOLD_CYCLES(16),
        .CS_IDLE_CYCLES (64),
        .WDT_CYCLES     (100)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .boot_req_i    (boot_req),
        .spi_cs_i      (spi_cs),
        .monitor_valid (mv),
        .soc_rst_n_o   (soc_rst_n),
        .fetch_enable_o(fe),
        .state_o       (st),
        .wdt_expired_o (wdt_exp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_st(input string n, input logic [1:0] s);
        exp_t e;
        e.name = n;
        e.st   = s;
        sb_q.push_back(e);
    endtask

    task automatic step(input string n, input logic [1:0] s, input int k);
        repeat (k) begin
            tick();
            expect_st(n, s);
        end
    endtask

    // Monitor: one expectation per falling edge, compared on all outputs.
    initial begin : mon
        exp_t       e;
        logic [4:0] got;
        logic [4:0] want;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e    = sb_q.pop_front();
                want = {e.st, e.st != S_HOLD, e.st == S_RUN, e.st == S_FAULT};
                got  = {st, soc_rst_n, fe, wdt_exp};
                compared++;
                if (got !== want) begin
                    mismatched++;
                    $display("FAIL %s @%0t: got st=%0d rst_n=%b fe=%b wdt=%b, want st=%0d rst_n=%b fe=%b wdt=%b",
                             e.name, $time, got[4:3], got[2], got[1], got[0],
                             want[4:3], want[2], want[1], want[0]);
                end
            end
        end
    end

    initial begin : stim
        repeat (2) tick();
        expect_st("reset_state", S_HOLD);
        tick();
        rst_n = 1'b1;
        expect_st("hold_cnt0", S_HOLD);
        step("hold", S_HOLD, 15);
        step("hold_to_load", S_LOAD, 1);

        step("load_no_cs", S_LOAD, 1000);
        boot_req = 1'b1;
        step("load_skip", S_RUN, 1);
        boot_req = 1'b0;

        for (int i = 0; i < 4; i++) begin
            step("wdt_fed", S_RUN, 49);
            mv = 1'b1;
            step("wdt_fed_mv", S_RUN, 1);
            mv = 1'b0;
        end
        step("wdt_count", S_RUN, 99);
        step("wdt_fault", S_FAULT, 1);
        mv = 1'b1;
        step("fault_sticky", S_FAULT, 5);
        mv = 1'b0;
        boot_req = 1'b1;
        step("fault_exit", S_HOLD, 1);
        step("hold_ignore_req", S_HOLD, 4);
        boot_req = 1'b0;
        step("hold_b", S_HOLD, 11);
        step("hold_b_to_load", S_LOAD, 1);

        spi_cs = 1'b0;
        step("cs_low", S_LOAD, 10);
        spi_cs = 1'b1;
        step("idle_pre_glitch", S_LOAD, 42);
        spi_cs = 1'b0;
        step("glitch", S_LOAD, 1);
        spi_cs = 1'b1;
        step("idle_restart", S_LOAD, 65);
        step("glitch_load_done", S_RUN, 1);

        step("pre_expiry", S_RUN, 99);
        boot_req = 1'b1;
        step("req_on_expiry", S_HOLD, 1);
        boot_req = 1'b0;
        step("hold_c", S_HOLD, 15);
        step("hold_c_to_load", S_LOAD, 1);

        spi_cs = 1'b0;
        step("cs_low_b", S_LOAD, 10);
        spi_cs = 1'b1;
        step("idle_b", S_LOAD, 65);
        step("load_done", S_RUN, 1);

        mv = 1'b1;
        step("run_mv", S_RUN, 3);
        mv = 1'b0;
        step("run_idle", S_RUN, 10);
        tick();
        rst_n = 1'b0;
        #1;
        expect_st("async_reset", S_HOLD);
        tick();
        expect_st("reset_held", S_HOLD);
        rst_n = 1'b1;
        step("hold_d", S_HOLD, 15);
        step("hold_d_to_load", S_LOAD, 1);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: got %0d pending, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
